// File: rtl/pwm_peripheral_if.sv
// Control bytes written by the SPI register block and consumed by the PWM peripheral.
interface pwm_peripheral_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle
    );

    modport slave (
        input en_reg_out_7_0,
        input en_reg_out_15_8,
        input en_reg_pwm_7_0,
        input en_reg_pwm_15_8,
        input pwm_duty_cycle
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16 general-purpose outputs, each off, static high, or driven by one shared PWM waveform.
// Duty cycle is double-buffered and only reloaded at the period boundary.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_peripheral_if.slave    ctrl,
    output logic [15:0]        out,
    output logic               pwm_sync
);

    localparam int unsigned    PresW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(CLK_DIV - 1);

    logic [PresW-1:0] prescaler_q, prescaler_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       duty_shadow_q, duty_shadow_d;
    logic             pwm_sync_q, pwm_sync_d;
    logic [15:0]      out_q, out_d;
    logic             tick;
    logic             boundary;
    logic             pwm_raw;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;

    assign en_out = {ctrl.en_reg_out_15_8, ctrl.en_reg_out_7_0};
    assign en_pwm = {ctrl.en_reg_pwm_15_8, ctrl.en_reg_pwm_7_0};

    always_comb begin
        tick        = (prescaler_q == PresMax);
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    // The period ends on the tick that wraps pwm_cnt; the new duty is sampled on that edge.
    always_comb begin
        boundary      = tick && (pwm_cnt_q == 8'hFF);
        duty_shadow_d = boundary ? ctrl.pwm_duty_cycle : duty_shadow_q;
        pwm_sync_d    = boundary;
    end

    // 0xFF is special-cased so full duty never dips low at cnt==255.
    always_comb begin
        pwm_raw = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);
        out_d   = en_out & (~en_pwm | {16{pwm_raw}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q   <= '0;
            pwm_cnt_q     <= 8'd0;
            duty_shadow_q <= 8'd0;
            pwm_sync_q    <= 1'b0;
            out_q         <= 16'd0;
        end else begin
            prescaler_q   <= prescaler_d;
            pwm_cnt_q     <= pwm_cnt_d;
            duty_shadow_q <= duty_shadow_d;
            pwm_sync_q    <= pwm_sync_d;
            out_q         <= out_d;
        end
    end

    assign out      = out_q;
    assign pwm_sync = pwm_sync_q;

endmodule
